// File: rtl/bus_pkg.sv
// Shared encodings for the 8-bit bus sequencer: command opcodes, FSM states, bus width.
// No logic; pure type/constant definitions.
// No flow control of its own.
package bus_pkg;

    localparam int BUS_W = 8;

    // Command opcodes as carried on cmd_op.
    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_MOVE     = 2'd1,
        OP_CLEAR    = 2'd2,
        OP_LOAD_IMM = 2'd3
    } op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // True when a register index addresses an existing register.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder with a global enable; all zeros when disabled or out of range.
// Latency: purely combinational.
// No backpressure; output follows inputs.
module onehot_decoder #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    // One bit per register; an index beyond N-1 matches no bit.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Bus master: sequences MOVE / LOAD_IMM / CLEAR commands onto per-register bus control lines.
// Latency accept->done: MOVE/LOAD_IMM SETTLE_CYCLES+2, CLEAR 2, NOP/rejected 1.
// One command in flight; cmd_ready is high only in IDLE, so a held cmd_valid waits.
module bus_transfer_sequencer
    import bus_pkg::*;
#(
    parameter int NUM_REGS      = 2,
    parameter int IDX_W         = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [IDX_W-1:0]     cmd_src,
    input  logic [IDX_W-1:0]     cmd_dst,
    input  logic [BUS_W-1:0]     cmd_imm,
    inout  wire  [BUS_W-1:0]     bus,
    output logic [NUM_REGS-1:0]  reg_data_out,
    output logic [NUM_REGS-1:0]  reg_data_in,
    output logic [NUM_REGS-1:0]  reg_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           xfer_count
);

    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e                state_q,    state_d;
    op_e                   op_q,       op_d;
    logic [IDX_W-1:0]      src_q,      src_d;
    logic [IDX_W-1:0]      dst_q,      dst_d;
    logic [BUS_W-1:0]      imm_q,      imm_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  done_q,     done_d;
    logic                  err_q,      err_d;
    logic                  bus_en_q,   bus_en_d;
    logic [7:0]            count_q,    count_d;
    logic [NUM_REGS-1:0]   data_out_q, data_out_d;
    logic [NUM_REGS-1:0]   data_in_q,  data_in_d;
    logic [NUM_REGS-1:0]   clr_q,      clr_d;

    op_e                   cmd_op_e;
    logic                  cmd_reject;
    logic                  out_en_d;
    logic                  in_en_d;
    logic                  clr_en_d;

    assign cmd_op_e = op_e'(cmd_op);

    // Validation of the incoming command; NOP carries no indices and is never rejected.
    always_comb begin
        cmd_reject = 1'b0;
        if (cmd_op_e != OP_NOP) begin
            if (!idx_in_range(32'(cmd_dst), NUM_REGS)) begin
                cmd_reject = 1'b1;
            end
            if (cmd_op_e == OP_MOVE) begin
                if (!idx_in_range(32'(cmd_src), NUM_REGS) || (cmd_src == cmd_dst)) begin
                    cmd_reject = 1'b1;
                end
            end
        end
    end

    // Next-state, command latch, settle counter, completion flags and transfer count.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op_e;
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    imm_d = cmd_imm;
                    cnt_d = '0;
                    if (cmd_reject || (cmd_op_e == OP_NOP)) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        err_d   = cmd_reject;
                    end else if (cmd_op_e == OP_CLEAR) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH, ST_CLEAR: begin
                // Only successful transfers reach FINISH through these states.
                state_d = ST_FINISH;
                done_d  = 1'b1;
                count_d = count_q + 8'd1;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output enables for the upcoming cycle, from next state and next latched command.
    always_comb begin
        out_en_d = (op_d == OP_MOVE) && ((state_d == ST_DRIVE) || (state_d == ST_LATCH));
        bus_en_d = (op_d == OP_LOAD_IMM) && ((state_d == ST_DRIVE) || (state_d == ST_LATCH));
        in_en_d  = (state_d == ST_LATCH);
        clr_en_d = (state_d == ST_CLEAR);
    end

    onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_dec_out (
        .idx    (src_d),
        .en     (out_en_d),
        .onehot (data_out_d)
    );

    onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_dec_in (
        .idx    (dst_d),
        .en     (in_en_d),
        .onehot (data_in_d)
    );

    onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_dec_clr (
        .idx    (dst_d),
        .en     (clr_en_d),
        .onehot (clr_d)
    );

    // All state and every output-driving flop; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bus_en_q   <= 1'b0;
            count_q    <= 8'd0;
            data_out_q <= '0;
            data_in_q  <= '0;
            clr_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            bus_en_q   <= bus_en_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            data_in_q  <= data_in_d;
            clr_q      <= clr_d;
        end
    end

    // Outputs come straight from flops or from the registered state only.
    assign bus          = bus_en_q ? imm_q : {BUS_W{1'bz}};
    assign reg_data_out = data_out_q;
    assign reg_data_in  = data_in_q;
    assign reg_clr      = clr_q;
    assign done         = done_q;
    assign err          = err_q;
    assign xfer_count   = count_q;
    assign busy         = (state_q != ST_IDLE);
    assign cmd_ready    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench: directed + random commands against a per-cycle expectation schedule.
// Bus registers are modelled behaviourally in the bench and checked against a shadow copy.
// Every cycle the full output vector is compared with the expected schedule entry.
module tb_bus_transfer_sequencer;

    localparam int N      = 3;
    localparam int IW     = 2;
    localparam int SETTLE = 2;

    typedef struct {
        logic [N-1:0] out_oh;
        logic [N-1:0] in_oh;
        logic [N-1:0] clr_oh;
        bit           drv;
        logic [7:0]   dat;
        bit           done;
        bit           err;
        bit           inc;
        bit           relchk;
    } exp_t;

    logic          clk;
    logic          clr_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_src;
    logic [IW-1:0] cmd_dst;
    logic [7:0]    cmd_imm;
    wire  [7:0]    bus;
    logic [N-1:0]  reg_data_out;
    logic [N-1:0]  reg_data_in;
    logic [N-1:0]  reg_clr;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    xfer_count;

    int   errors;
    int   checks;
    exp_t expq[$];
    bit   cur_idle;
    bit   last_acc;
    bit   init_done;
    logic [7:0] exp_cnt;
    logic [7:0] shadow [N];
    logic [7:0] prev   [N];
    logic [7:0] regs   [N];
    logic [7:0] reg_drv_dat;
    logic       reg_drv_en;

    bus_transfer_sequencer #(.NUM_REGS(N), .IDX_W(IW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_src      (cmd_src),
        .cmd_dst      (cmd_dst),
        .cmd_imm      (cmd_imm),
        .bus          (bus),
        .reg_data_out (reg_data_out),
        .reg_data_in  (reg_data_in),
        .reg_clr      (reg_clr),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .xfer_count   (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bus registers: drive when selected, capture / clear at the clock edge.
    always_comb begin
        reg_drv_en  = |reg_data_out;
        reg_drv_dat = 8'h00;
        for (int i = 0; i < N; i++) if (reg_data_out[i]) reg_drv_dat = regs[i];
    end
    assign bus = reg_drv_en ? reg_drv_dat : 8'bz;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!init_done)         regs[i] <= 8'h00;
            else if (reg_clr[i])    regs[i] <= 8'h00;
            else if (reg_data_in[i]) regs[i] <= bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e.out_oh = '0; e.in_oh = '0; e.clr_oh = '0;
        e.drv = 0; e.dat = 8'h00; e.done = 0; e.err = 0; e.inc = 0; e.relchk = 0;
        return e;
    endfunction

    // Reference model: expand one accepted command into its per-cycle expectations.
    task automatic plan(input logic [1:0] op, input logic [IW-1:0] src, input logic [IW-1:0] dst,
                        input logic [7:0] imm);
        exp_t e;
        int   s, d;
        bit   rej;
        s = int'(src);
        d = int'(dst);
        for (int i = 0; i < N; i++) prev[i] = shadow[i];
        rej = (op != 2'd0) && ((d >= N) || ((op == 2'd1) && ((s >= N) || (s == d))));
        if (op == 2'd0 || rej) begin
            e = blank(); e.done = 1; e.err = rej; expq.push_back(e);
        end else if (op == 2'd1) begin
            for (int c = 0; c < SETTLE; c++) begin
                e = blank(); e.out_oh = oh(s); expq.push_back(e);
            end
            e = blank(); e.out_oh = oh(s); e.in_oh = oh(d); expq.push_back(e);
            shadow[d] = shadow[s];
            e = blank(); e.done = 1; e.inc = 1; expq.push_back(e);
        end else if (op == 2'd3) begin
            for (int c = 0; c < SETTLE; c++) begin
                e = blank(); e.drv = 1; e.dat = imm; expq.push_back(e);
            end
            e = blank(); e.drv = 1; e.dat = imm; e.in_oh = oh(d); expq.push_back(e);
            shadow[d] = imm;
            e = blank(); e.done = 1; e.inc = 1; e.relchk = 1; e.dat = imm; expq.push_back(e);
        end else begin
            e = blank(); e.clr_oh = oh(d); expq.push_back(e);
            shadow[d] = 8'h00;
            e = blank(); e.done = 1; e.inc = 1; expq.push_back(e);
        end
    endtask

    // One clock: predict acceptance, advance, then compare every output with the schedule.
    task automatic cycle();
        exp_t e;
        bit   acc;
        acc = cmd_valid && cur_idle && clr_n;
        if (acc) plan(cmd_op, cmd_src, cmd_dst, cmd_imm);
        @(posedge clk);
        #1;
        last_acc = acc;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            cur_idle = 0;
        end else begin
            e = blank();
            cur_idle = 1;
        end
        if (e.inc) exp_cnt = exp_cnt + 8'd1;
        check("cmd_ready",    32'(cmd_ready),    32'(cur_idle));
        check("busy",         32'(busy),         32'(!cur_idle));
        check("done",         32'(done),         32'(e.done));
        check("err",          32'(err),          32'(e.err));
        check("reg_data_out", 32'(reg_data_out), 32'(e.out_oh));
        check("reg_data_in",  32'(reg_data_in),  32'(e.in_oh));
        check("reg_clr",      32'(reg_clr),      32'(e.clr_oh));
        check("xfer_count",   32'(xfer_count),   32'(exp_cnt));
        if (e.drv)    check("bus_imm",     32'(bus),           32'(e.dat));
        if (e.relchk) check("bus_release", 32'(bus !== e.dat), 32'd1);
        if (e.done) begin
            for (int i = 0; i < N; i++) check("reg_contents", 32'(regs[i]), 32'(shadow[i]));
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [IW-1:0] src, input logic [IW-1:0] dst,
                         input logic [7:0] imm);
        bit got;
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        cmd_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            cycle();
            got = last_acc;
        end
        check("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        cmd_valid = 1'b0;
        for (int n = 0; n < 50 && !cur_idle; n++) cycle();
        check("idle_timeout", 32'(cur_idle), 32'd1);
    endtask

    initial begin
        logic [1:0]    rop;
        logic [IW-1:0] rs, rd;
        logic [7:0]    rimm;
        errors = 0; checks = 0;
        exp_cnt = 8'd0; cur_idle = 1; last_acc = 0; init_done = 0;
        for (int i = 0; i < N; i++) begin shadow[i] = 8'h00; prev[i] = 8'h00; end
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = '0; cmd_dst = '0; cmd_imm = 8'h00;

        // Power-on reset.
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 32'(reg_data_out), 32'd0);
        check("rst_data_in",  32'(reg_data_in),  32'd0);
        check("rst_clr",      32'(reg_clr),      32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_err",      32'(err),          32'd0);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_count",    32'(xfer_count),   32'd0);
        clr_n = 1'b1;
        init_done = 1;
        cycle();
        cycle();

        // Directed: preload, MOVE, LOAD_IMM, CLEAR.
        issue(2'd3, 2'd0, 2'd0, 8'hA5); wait_idle();
        issue(2'd1, 2'd0, 2'd1, 8'h00); wait_idle();
        check("move_reg1",   32'(regs[1]),    32'h0A5);
        check("move_count",  32'(xfer_count), 32'd2);
        issue(2'd3, 2'd0, 2'd0, 8'h3C); wait_idle();
        check("load_reg0",   32'(regs[0]),    32'h03C);
        issue(2'd2, 2'd0, 2'd1, 8'h00); wait_idle();
        check("clear_reg1",  32'(regs[1]),    32'h000);

        // Directed rejections and NOP.
        issue(2'd1, 2'd1, 2'd1, 8'h00); wait_idle();
        issue(2'd1, 2'd0, 2'd3, 8'h00); wait_idle();
        issue(2'd1, 2'd3, 2'd0, 8'h00); wait_idle();
        issue(2'd2, 2'd0, 2'd3, 8'h00); wait_idle();
        issue(2'd3, 2'd0, 2'd3, 8'h77); wait_idle();
        issue(2'd0, 2'd0, 2'd0, 8'h00); wait_idle();
        check("reject_count", 32'(xfer_count), 32'd4);

        // Random commands with random idle gaps; inputs change freely while busy.
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(2, 0)) begin
                cmd_valid = 1'b0;
                cmd_op = 2'($urandom); cmd_src = IW'($urandom); cmd_dst = IW'($urandom);
                cmd_imm = 8'($urandom);
                cycle();
            end
            rop  = 2'($urandom_range(3, 0));
            rs   = IW'($urandom_range(3, 0));
            rd   = IW'($urandom_range(3, 0));
            rimm = 8'($urandom_range(255, 1));
            if (rop == 2'd0) begin rs = '0; rd = '0; end
            issue(rop, rs, rd, rimm);
        end
        wait_idle();

        // Reset asserted mid-LATCH of a MOVE: transfer aborted, no done, count cleared.
        issue(2'd3, 2'd0, 2'd0, 8'h5A); wait_idle();
        issue(2'd1, 2'd0, 2'd2, 8'h00);
        cmd_valid = 1'b0;
        repeat (SETTLE) cycle();
        #2 clr_n = 1'b0;
        #1;
        check("abort_data_out", 32'(reg_data_out), 32'd0);
        check("abort_data_in",  32'(reg_data_in),  32'd0);
        check("abort_busy",     32'(busy),         32'd0);
        check("abort_count",    32'(xfer_count),   32'd0);
        @(posedge clk);
        #1;
        check("abort_done",     32'(done),         32'd0);
        clr_n = 1'b1;
        expq.delete();
        for (int i = 0; i < N; i++) shadow[i] = prev[i];
        exp_cnt = 8'd0;
        cur_idle = 1;
        cycle();
        check("abort_reg2_kept", 32'(regs[2]), 32'(shadow[2]));

        // 256 back-to-back successful MOVEs with cmd_valid held high: count wraps to 0.
        for (int k = 0; k < 256; k++) begin
            issue(2'd1, IW'(k % N), IW'((k + 1) % N), 8'($urandom));
        end
        wait_idle();
        check("wrap_count", 32'(xfer_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
